pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle fetch/execute controller that owns and sequences the CPU program counter. It issues instruction-fetch requests, and it waits for execution to complete. It then selects the next PC: sequential, branch or jump. The block stops the machine when the PC reaches the halt address. It sits between the instruction memory, the decode/execute datapath and the rest of the core, and it replaces free-running PC update with a controlled handshake.

## Interface
- WIDTH, 32, PC width
- RESET_ADDR, 32'h0, PC value after reset
- HALT_ADDR, 32'h5c, PC value that ends execution
- INCR, 4, sequential PC step
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start  in  1  begin execution (honoured only in IDLE)
- imem_ack  in  1  instruction memory has valid data this cycle
- exec_done  in  1  datapath finished current instruction
- jump  in  1  unconditional redirect (sampled with exec_done)
- jump_target  in  WIDTH  jump destination
- branch_taken  in  1  conditional redirect (sampled with exec_done)
- branch_target  in  WIDTH  branch destination
- pc  out  WIDTH  current PC (registered)
- pc_next  out  WIDTH  pc + INCR, combinational
- imem_req  out  1  fetch request
- ir_load  out  1  instruction register load strobe
- exec_start  out  1  one-cycle pulse starting execution
- halted  out  1  high while in HALT
- retired  out  16  count of completed instructions
- state  out  2  IDLE=0, FETCH=1, EXEC=2, HALT=3

## Operation
- IDLE: all strobes low. If start=1 → FETCH, or → HALT if RESET_ADDR==HALT_ADDR. pc is unchanged.
- FETCH: imem_req=1. ir_load = imem_req & imem_ack (combinational). When imem_ack=1 → EXEC. Otherwise the block stays in FETCH, and imem_req stays high.
- EXEC: exec_start=1 only in the first cycle after entering EXEC; it is registered. The block waits for exec_done=1. On that edge:
  - next PC priority: jump → jump_target; else branch_taken → branch_target; else pc_next.
  - target bits [1:0] are forced to 0.
  - retired increments and saturates at 16'hFFFF.
  - If the selected next PC == HALT_ADDR → HALT, otherwise → FETCH. pc loads the selected value in both cases.
- HALT: halted=1 and all strobes are low. The state is sticky; only reset leaves HALT.
- Inputs outside their states are ignored: start outside IDLE, imem_ack outside FETCH, exec_done/jump/branch_taken outside EXEC.
- pc_next = pc + INCR modulo 2^WIDTH. Carry is discarded, so pc=32'hFFFFFFFC gives pc_next=0.
- jump and branch_taken both high: jump wins.
- exec_done high on the same cycle as the exec_start pulse is legal. The instruction completes that cycle.

## Timing
- Reset values: state=IDLE, pc=RESET_ADDR, retired=0, exec_start=0, halted=0. imem_req and ir_load are 0 because they are decoded from IDLE.
- Asserting reset in any state (mid-fetch or mid-exec) aborts immediately. imem_req drops without waiting for a clock edge, and no retired increment occurs.
- start sampled at edge k → state=FETCH and imem_req=1 after edge k.
- Minimum instruction period is 2 cycles: 1 FETCH cycle with ack, then 1 EXEC cycle with exec_done.
- Each additional cycle of imem_ack or exec_done latency adds exactly one cycle.
- pc updates on the exec_done edge. The new value is visible in the following FETCH cycle.
- halted rises one cycle after the exec_done edge that selected HALT_ADDR.

## Test plan
- Reset, start, and imem_ack/exec_done tied high:
  - pc steps 0,4,8,…,0x58, one step every 2 cycles.
  - Reaching 0x5c gives halted=1 and retired=23.
  - After that, imem_req stays 0.
- imem_ack delayed 3 cycles:
  - imem_req stays high 4 cycles.
  - ir_load pulses once.
  - exec_start pulses one cycle after ack.
- At pc=0x10:
  - with jump=1, jump_target=0x40 and branch_taken=1, branch_target=0x20, next pc=0x40.
  - with branch_target=0x23 and no jump, next pc=0x20.
- Preload pc=32'hFFFFFFFC via RESET_ADDR override and complete one instruction → pc=0, no halt.
- Reset asserted mid-EXEC at pc=0x30:
  - state=IDLE, pc=0 and retired=0 without a clock edge.
  - start and exec_done pulses while in IDLE have no effect on pc until start is honoured.
- exec_done asserted during FETCH and imem_ack asserted during EXEC: both are ignored, with no pc change and no state skip.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute controller that owns the CPU program counter.
// It requests an instruction, waits for the fetch acknowledge, starts
// execution and waits for completion. It then loads the next PC, which is
// the sequential step, a branch target or a jump target. The machine parks
// in HALT once the selected next PC equals the halt address.
module pc_sequencer #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0,
  parameter logic [WIDTH-1:0] HALT_ADDR  = 32'h5c,
  parameter int               INCR       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             imem_ack,
  input  logic             exec_done,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             imem_req,
  output logic             ir_load,
  output logic             exec_start,
  output logic             halted,
  output logic [15:0]      retired,
  output logic [1:0]       state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  // Redirect targets are word aligned; the two low bits are always cleared.
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  // Retired-instruction counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) sat_inc16 = v;
    else               sat_inc16 = v + 16'd1;
  endfunction

  logic [1:0]       cur_state;
  logic [1:0]       nxt_state;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] sel_pc;
  logic [15:0]      retired_q;
  logic             exec_start_q;
  logic             done_fire;

  // Sequential step; carry out of the top bit is dropped.
  assign pc_next   = pc_q + WIDTH'(INCR);
  assign done_fire = (cur_state == EXEC) && exec_done;

  // Next-PC selection: jump beats branch, branch beats sequential.
  always_comb begin
    sel_pc = pc_next;
    if (jump)              sel_pc = jump_target;
    else if (branch_taken) sel_pc = branch_target;
    sel_pc = sel_pc & ALIGN_MASK;
  end

  // Next-state decode; each state only listens to its own handshake input.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (start)     nxt_state = (RESET_ADDR == HALT_ADDR) ? HALT : FETCH;
      FETCH:   if (imem_ack)  nxt_state = EXEC;
      EXEC:    if (exec_done) nxt_state = (sel_pc == HALT_ADDR) ? HALT : FETCH;
      default:                nxt_state = HALT;
    endcase
  end

  // State register; reset aborts any fetch or execution in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= nxt_state;
  end

  // PC loads the selected target on the completing edge of an instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          pc_q <= RESET_ADDR;
    else if (done_fire) pc_q <= sel_pc;
  end

  // Count completed instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          retired_q <= 16'd0;
    else if (done_fire) retired_q <= sat_inc16(retired_q);
  end

  // Registered one-cycle pulse in the first EXEC cycle, set by the fetch ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) exec_start_q <= 1'b0;
    else       exec_start_q <= (cur_state == FETCH) && imem_ack;
  end

  assign pc         = pc_q;
  assign retired    = retired_q;
  assign exec_start = exec_start_q;
  assign state      = cur_state;
  assign imem_req   = (cur_state == FETCH);
  assign ir_load    = imem_req && imem_ack;
  assign halted     = (cur_state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected PCs go into a scoreboard queue
// when an instruction is completed and are popped when the DUT shows them.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, imem_ack, exec_done, jump, branch_taken;
  logic [31:0] jump_target, branch_target;
  logic [31:0] pc, pc_next;
  logic        imem_req, ir_load, exec_start, halted;
  logic [15:0] retired;
  logic [1:0]  state;

  logic        start2, ack2, done2;
  logic [31:0] pc2, pc_next2;
  logic        imem_req2, ir_load2, exec_start2, halted2;
  logic [15:0] retired2;
  logic [1:0]  state2;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;
  logic [15:0] exp_ret;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .imem_ack(imem_ack),
    .exec_done(exec_done), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .pc_next(pc_next), .imem_req(imem_req), .ir_load(ir_load),
    .exec_start(exec_start), .halted(halted), .retired(retired), .state(state)
  );

  pc_sequencer #(.RESET_ADDR(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .imem_ack(ack2),
    .exec_done(done2), .jump(1'b0), .jump_target(32'h0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .pc(pc2), .pc_next(pc_next2), .imem_req(imem_req2), .ir_load(ir_load2),
    .exec_start(exec_start2), .halted(halted2), .retired(retired2), .state(state2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic j,
                                              input logic [31:0] jt, input logic b,
                                              input logic [31:0] bt);
    logic [31:0] r;
    r = cur + 32'd4;
    if (j)      r = jt;
    else if (b) r = bt;
    return {r[31:2], 2'b00};
  endfunction

  // One instruction starting at a negedge in FETCH. With noise set, the
  // inputs belonging to the other state are driven high while waiting.
  task automatic step_instr(input int ack_dly, input int done_dly, input logic j,
                            input logic [31:0] jt, input logic b, input logic [31:0] bt,
                            input logic noise);
    logic [31:0] nxt;
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack = 1'b0; exec_done = noise; jump = noise; jump_target = 32'h44;
      #1;
      check("fetch_state", 32'(state), 32'd1);
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_irload_low", 32'(ir_load), 32'd0);
      check("fetch_pc", pc, exp_pc);
      @(negedge clk);
    end
    exec_done = 1'b0; jump = 1'b0; imem_ack = 1'b1;
    #1;
    check("fetch_state_ack", 32'(state), 32'd1);
    check("ir_load_on_ack", 32'(ir_load), 32'd1);
    @(negedge clk);
    imem_ack = 1'b0;
    check("exec_state", 32'(state), 32'd2);
    check("exec_start_pulse", 32'(exec_start), 32'd1);
    check("exec_req_low", 32'(imem_req), 32'd0);
    check("exec_irload_low", 32'(ir_load), 32'd0);
    for (int i = 0; i < done_dly; i++) begin
      imem_ack = noise;
      @(negedge clk);
      imem_ack = 1'b0;
      check("exec_wait_state", 32'(state), 32'd2);
      check("exec_start_low", 32'(exec_start), 32'd0);
      check("exec_wait_pc", pc, exp_pc);
    end
    exec_done = 1'b1; jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
    nxt = model_next(exp_pc, j, jt, b, bt);
    sb.push_back(nxt);
    if (exp_ret != 16'hFFFF) exp_ret = exp_ret + 16'd1;
    @(negedge clk);
    exec_done = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    exp_pc = sb.pop_front();
    check("pc_update", pc, exp_pc);
    check("retired", 32'(retired), 32'(exp_ret));
    check("post_exec_state", 32'(state), (exp_pc == 32'h5c) ? 32'd3 : 32'd1);
    check("pc_next", pc_next, exp_pc + 32'd4);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    jump = 1'b0; branch_taken = 1'b0; jump_target = '0; branch_target = '0;
    start2 = 1'b0; ack2 = 1'b0; done2 = 1'b0;
    exp_pc = 32'h0; exp_ret = 16'd0;
    @(negedge clk); @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_exec_start", 32'(exec_start), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_ir_load", 32'(ir_load), 32'd0);
    check("rst_pc2", pc2, 32'hFFFF_FFFC);
    check("pc_next2_wrap", pc_next2, 32'h0);
    reset = 1'b0;

    // Run with imem_ack and exec_done tied high from start to halt.
    for (int n = 0; n < 23; n++) sb.push_back(32'(n * 4));
    imem_ack = 1'b1; exec_done = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 23; n++) begin
      exp_pc = sb.pop_front();
      check("run_fetch_state", 32'(state), 32'd1);
      check("run_fetch_pc", pc, exp_pc);
      check("run_fetch_req", 32'(imem_req), 32'd1);
      @(negedge clk);
      check("run_exec_state", 32'(state), 32'd2);
      check("run_exec_start", 32'(exec_start), 32'd1);
      check("run_exec_pc", pc, exp_pc);
      @(negedge clk);
    end
    check("run_halt_state", 32'(state), 32'd3);
    check("run_halted", 32'(halted), 32'd1);
    check("run_halt_pc", pc, 32'h5c);
    check("run_retired23", 32'(retired), 32'd23);
    start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("halt_req_low", 32'(imem_req), 32'd0);
      check("halt_sticky", 32'(halted), 32'd1);
      check("halt_exec_start_low", 32'(exec_start), 32'd0);
      check("halt_pc_hold", pc, 32'h5c);
    end
    start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;

    // Reset out of HALT, then directed instructions.
    reset = 1'b1;
    #1;
    check("rst2_state", 32'(state), 32'd0);
    check("rst2_halted", 32'(halted), 32'd0);
    check("rst2_pc", pc, 32'h0);
    @(negedge clk);
    reset = 1'b0; exp_pc = 32'h0; exp_ret = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_fetch", 32'(state), 32'd1);
    step_instr(3, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step_instr(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step_instr(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step_instr(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("at_0x10", pc, 32'h10);
    step_instr(0, 1, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0);
    step_instr(0, 0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    step_instr(0, 0, 1'b0, 32'h0, 1'b1, 32'h23, 1'b0);
    check("branch_aligned", pc, 32'h20);
    step_instr(2, 2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step_instr(0, 0, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of EXEC at pc=0x30.
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("pre_abort_state", 32'(state), 32'd2);
    check("pre_abort_pc", pc, 32'h30);
    #2 reset = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_pc", pc, 32'h0);
    check("abort_retired", 32'(retired), 32'd0);
    check("abort_exec_start", 32'(exec_start), 32'd0);
    check("abort_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    reset = 1'b0; exp_pc = 32'h0; exp_ret = 16'd0;
    exec_done = 1'b1; jump = 1'b1; jump_target = 32'h40; imem_ack = 1'b1;
    @(negedge clk);
    exec_done = 1'b0; jump = 1'b0; imem_ack = 1'b0;
    check("idle_ignore_state", 32'(state), 32'd0);
    check("idle_ignore_pc", pc, 32'h0);
    check("idle_ignore_retired", 32'(retired), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_fetch", 32'(state), 32'd1);
    step_instr(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Wrap-around instance: one instruction from 0xFFFFFFFC.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; ack2 = 1'b1;
    check("wrap_fetch", 32'(state2), 32'd1);
    @(negedge clk);
    ack2 = 1'b0; done2 = 1'b1;
    check("wrap_exec", 32'(state2), 32'd2);
    @(negedge clk);
    done2 = 1'b0;
    check("wrap_pc", pc2, 32'h0);
    check("wrap_no_halt", 32'(halted2), 32'd0);
    check("wrap_state", 32'(state2), 32'd1);
    check("wrap_retired", 32'(retired2), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
